// File: rtl/regfile_sb_if.sv
// Decode/write-back bus of the scoreboarded register file.
// master = decode and write-back stages, slave = register file.
interface regfile_sb_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_ok;
    logic [AW:0]     busy_cnt;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ok, busy_cnt
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ok, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port and a
// per-register busy scoreboard for RAW hazard detection.
module regfile_sb #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned AW         = 5,
    parameter bit          INIT_INDEX = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_ok;
    logic             rsv_hit_wr;
    logic             rsv_ok;
    logic             cnt_inc, cnt_dec;

    logic [AW-1:0]    rd_addr [2];
    logic [XLEN-1:0]  rd_data [2];
    logic             rd_busy [2];

    // Address 0 and addresses beyond NREGS are treated as non-existent.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    always_comb begin
        wr_ok      = bus.wr_en && addr_ok(bus.wr_addr);
        rsv_hit_wr = wr_ok && (bus.wr_addr == bus.rsv_addr);
        rsv_ok     = bus.rsv_en && addr_ok(bus.rsv_addr) &&
                     (!busy_q[bus.rsv_addr] || rsv_hit_wr);

        // Clear before set so a same-cycle reserve leaves the register busy.
        busy_d = busy_q;
        if (wr_ok) busy_d[bus.wr_addr] = 1'b0;
        if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;

        cnt_inc = rsv_ok && !busy_q[bus.rsv_addr];
        cnt_dec = wr_ok && busy_q[bus.wr_addr] && !(rsv_ok && rsv_hit_wr);
        cnt_d   = cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end

    always_comb begin
        rd_addr[0] = bus.rs1_addr;
        rd_addr[1] = bus.rs2_addr;
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (addr_ok(rd_addr[p])) begin
                if (BYPASS && wr_ok && (bus.wr_addr == rd_addr[p])) begin
                    rd_data[p] = bus.wr_data;
                end else begin
                    rd_data[p] = regs_q[rd_addr[p]];
                    rd_busy[p] = busy_q[rd_addr[p]];
                end
            end
        end
    end

    assign bus.rs1_data = rd_data[0];
    assign bus.rs2_data = rd_data[1];
    assign bus.rs1_busy = rd_busy[0];
    assign bus.rs2_busy = rd_busy[1];
    assign bus.rsv_ok   = rsv_ok;
    assign bus.busy_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= INIT_INDEX ? XLEN'(i) : '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) regs_q[bus.wr_addr] <= bus.wr_data;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, x0, scoreboard and reset mid-operation.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    regfile_sb_if #(.XLEN(32), .AW(5)) bus ();

    regfile_sb #(
        .XLEN      (32),
        .NREGS     (32),
        .AW        (5),
        .INIT_INDEX(1'b1),
        .BYPASS    (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
    endtask

    // Advance past the next rising edge, then clear inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Reset values
        bus.rs1_addr = 5'd7;
        bus.rs2_addr = 5'd31;
        #1;
        chk("rst_rs1_data", 64'(bus.rs1_data), 64'd7);
        chk("rst_rs2_data", 64'(bus.rs2_data), 64'd31);
        chk("rst_rs1_busy", 64'(bus.rs1_busy), 64'd0);
        chk("rst_rs2_busy", 64'(bus.rs2_busy), 64'd0);
        chk("rst_cnt", 64'(bus.busy_cnt), 64'd0);

        // Write with same-cycle bypass, then stored value
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
        bus.rs1_addr = 5'd5;
        #1;
        chk("byp_rs1_data", 64'(bus.rs1_data), 64'hDEADBEEF);
        chk("byp_rs1_busy", 64'(bus.rs1_busy), 64'd0);
        tick();
        bus.rs1_addr = 5'd5;
        #1;
        chk("wr5_stored", 64'(bus.rs1_data), 64'hDEADBEEF);
        chk("wr5_cnt", 64'(bus.busy_cnt), 64'd0);

        // Register 0
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234;
        bus.rs1_addr = 5'd0;
        #1;
        chk("x0_nobypass", 64'(bus.rs1_data), 64'd0);
        tick();
        bus.rs1_addr = 5'd0;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
        #1;
        chk("x0_read", 64'(bus.rs1_data), 64'd0);
        chk("x0_rsv_ok", 64'(bus.rsv_ok), 64'd0);
        tick();
        bus.rs1_addr = 5'd0;
        #1;
        chk("x0_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("x0_busy", 64'(bus.rs1_busy), 64'd0);

        // Reserve x3, re-reserve rejected, write-back clears
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        #1;
        chk("rsv3_ok", 64'(bus.rsv_ok), 64'd1);
        tick();
        bus.rs1_addr = 5'd3;
        #1;
        chk("rsv3_busy", 64'(bus.rs1_busy), 64'd1);
        chk("rsv3_cnt", 64'(bus.busy_cnt), 64'd1);
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        #1;
        chk("rsv3_again", 64'(bus.rsv_ok), 64'd0);
        tick();
        bus.rs1_addr = 5'd3;
        #1;
        chk("rsv3_hold_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("rsv3_hold_busy", 64'(bus.rs1_busy), 64'd1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hA5;
        bus.rs2_addr = 5'd3;
        #1;
        chk("wb3_rs2_data", 64'(bus.rs2_data), 64'hA5);
        chk("wb3_rs2_busy", 64'(bus.rs2_busy), 64'd0);
        chk("wb3_rs1_byp", 64'(bus.rs1_busy), 64'd0);
        tick();
        bus.rs2_addr = 5'd3;
        #1;
        chk("wb3_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("wb3_stored", 64'(bus.rs2_data), 64'hA5);
        chk("wb3_busy_after", 64'(bus.rs2_busy), 64'd0);

        // Same-address write and reserve on a busy register
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
        tick();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h44;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
        #1;
        chk("sim4_rsv_ok", 64'(bus.rsv_ok), 64'd1);
        chk("sim4_cnt_before", 64'(bus.busy_cnt), 64'd1);
        tick();
        bus.rs1_addr = 5'd4;
        #1;
        chk("sim4_data", 64'(bus.rs1_data), 64'h44);
        chk("sim4_busy", 64'(bus.rs1_busy), 64'd1);
        chk("sim4_cnt", 64'(bus.busy_cnt), 64'd1);

        // Write-back x4 while reserving x1: count stays level
        bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h45;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd1;
        #1;
        chk("mix_rsv_ok", 64'(bus.rsv_ok), 64'd1);
        tick();
        #1;
        chk("mix_cnt", 64'(bus.busy_cnt), 64'd1);
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd2;
        tick();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
        tick();
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd2;
        #1;
        chk("mid_cnt3", 64'(bus.busy_cnt), 64'd3);
        chk("mid_busy9", 64'(bus.rs1_busy), 64'd1);
        chk("mid_busy2", 64'(bus.rs2_busy), 64'd1);

        // Reset overrides a same-cycle write and reserve
        rst_n = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'hFFFF;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd5;
        tick();
        rst_n = 1'b1;
        bus.rs1_addr = 5'd2;
        bus.rs2_addr = 5'd1;
        #1;
        chk("rst2_data", 64'(bus.rs1_data), 64'd2);
        chk("rst2_busy", 64'(bus.rs1_busy), 64'd0);
        chk("rst1_busy", 64'(bus.rs2_busy), 64'd0);
        chk("rst_mid_cnt", 64'(bus.busy_cnt), 64'd0);
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd4;
        #1;
        chk("rst9_busy", 64'(bus.rs1_busy), 64'd0);
        chk("rst4_data", 64'(bus.rs2_data), 64'd4);
        bus.rs1_addr = 5'd5;
        #1;
        chk("rst5_data", 64'(bus.rs1_data), 64'd5);
        chk("rst5_busy", 64'(bus.rs1_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file with a per-register scoreboard, successor to the single-cycle core's fixed 32x32 register file. Provides two combinational read ports and one write port with optional write-to-read bypass. Also provides a reserve port that marks a destination register busy until its write-back arrives. Sits between decode (reads, reserve) and write-back, and lets a future multi-cycle or pipelined core detect RAW hazards.

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of architectural registers (2..64).
AW, 5, address width; must satisfy 2**AW >= NREGS.
INIT_INDEX, 1, 1: register i resets to value i (zero-extended); 0: all registers reset to 0.
BYPASS, 1, 1: a read of the address being written this cycle returns wr_data; 0: it returns the stored value.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
rs1_addr  in  AW  read port 1 address
rs2_addr  in  AW  read port 2 address
rs1_data  out  XLEN  read port 1 data
rs2_data  out  XLEN  read port 2 data
rs1_busy  out  1  scoreboard bit for rs1_addr
rs2_busy  out  1  scoreboard bit for rs2_addr
wr_en  in  1  write-back strobe
wr_addr  in  AW  write-back address
wr_data  in  XLEN  write-back data
rsv_en  in  1  reserve request
rsv_addr  in  AW  register to mark busy
rsv_ok  out  1  reserve accepted this cycle (combinational)
busy_cnt  out  AW+1  registered count of busy registers

Behaviour:
- Reset: rst_n sampled low at a rising edge sets register i to i (INIT_INDEX=1) or 0, clears all busy bits, sets busy_cnt=0. Reset overrides any write or reserve in the same cycle.
- Reset mid-operation discards outstanding reservations.
- Register 0: always reads 0, never busy. Writes and reserves to address 0 are ignored; rsv_ok=0 for address 0.
- Addresses >= NREGS: reads return 0 with busy=0; writes ignored; rsv_ok=0.
- Reads are combinational, zero latency: rsN_data = reg[rsN_addr], rsN_busy = busy[rsN_addr].
- Bypass (BYPASS=1): if wr_en, wr_addr==rsN_addr and wr_addr is valid and nonzero, then rsN_data=wr_data and rsN_busy=0 in the same cycle. With BYPASS=0, the new value is visible one cycle after the edge.
- Write: on a valid wr_en, reg[wr_addr] updates at the edge and busy[wr_addr] clears. Writing a non-busy register is legal: data updates and busy stays 0.
- Reserve:
  - rsv_ok=1 when rsv_en and rsv_addr is valid, nonzero, and either not busy or being written this cycle (wr_en and wr_addr==rsv_addr).
  - On rsv_ok, busy[rsv_addr] is set at the edge.
  - A reserve to a busy register with no matching write is rejected: rsv_ok=0, no state change. Decode must stall.
- Same-address write and reserve in one cycle: the data write completes, busy ends 1 (reserve wins), rsv_ok=1.
- busy_cnt: next = cnt + (reserve accepted on a register not already busy) - (write clears a busy register that is not re-reserved). Holds its value when both events occur on the same register. Never wraps; the maximum is NREGS-1.
- Read port outputs are undefined only while X on inputs; there are no other X sources after reset.

Test Plan:
- Reset with INIT_INDEX=1: hold rst_n=0 for 1 edge, read rs1=7, rs2=31 -> data 7 and 31, busy 0, busy_cnt=0.
- Write then read: wr_en, wr_addr=5, wr_data=0xDEADBEEF, rs1_addr=5 same cycle -> rs1_data=0xDEADBEEF combinationally (BYPASS=1). With BYPASS=0, old value 5 that cycle and 0xDEADBEEF the next.
- Register 0: write 0x1234 to x0, then read -> 0. Reserve x0 -> rsv_ok=0, busy_cnt unchanged.
- Scoreboard:
  - Reserve x3 -> rsv_ok=1; next cycle rs1_busy(x3)=1 and busy_cnt=1.
  - Reserve x3 again -> rsv_ok=0.
  - Write x3=0xA5 -> rs2 on x3 reads 0xA5 with busy 0 in the same cycle; busy_cnt=0 after the edge.
- Simultaneous events: x4 busy; wr_addr=4 and rsv_addr=4 in one cycle -> rsv_ok=1, reg4 updated, busy[4] stays 1, busy_cnt unchanged.
- Reset mid-operation: reserve x1, x2, x9 (busy_cnt=3), then assert rst_n=0 together with wr_en to x2 -> all busy clear, busy_cnt=0, reg2=2 (the write is discarded).
